// File: rtl/sdp_rdma_atom_split.sv
// Splits packed SDP RDMA words (up to 4 atoms plus a valid mask) into a one-atom-per-cycle stream.
// Counts atoms against the layer size, marks the final atom and pulses layer_done after it.
module sdp_rdma_atom_split #(
   parameter int AM_DW = 256,
   parameter int CNT_W = 14
) (
   input  logic                 nvdla_core_clk,
   input  logic                 nvdla_core_rstn,
   input  logic                 op_en,
   input  logic [CNT_W-1:0]     cfg_atom_num_m1,
   input  logic                 in_pvld,
   output logic                 in_prdy,
   input  logic [4*AM_DW+3:0]   in_data,
   output logic                 out_pvld,
   input  logic                 out_prdy,
   output logic [AM_DW-1:0]     out_data,
   output logic                 out_word_last,
   output logic                 out_layer_end,
   output logic                 layer_done,
   output logic                 err_mask,
   output logic                 err_ovf
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cfg;
   logic [CNT_W-1:0]    atom_cnt;
   logic                hold_vld;
   logic [4*AM_DW-1:0]  hold_data;
   logic [2:0]          hold_n;
   logic [1:0]          idx;
   logic [3:0]          in_mask;
   logic [2:0]          in_n;
   logic                in_acc;
   logic                out_acc;
   logic                end_acc;
   logic                word_last;

   assign in_mask = in_data[4*AM_DW +: 4];

   // Atom count is set by the highest mask bit; holes below it are still emitted.
   always_comb begin
      in_n = 3'd0;
      casez (in_mask)
         4'b1???: in_n = 3'd4;
         4'b01??: in_n = 3'd3;
         4'b001?: in_n = 3'd2;
         4'b0001: in_n = 3'd1;
         default: in_n = 3'd0;
      endcase
   end

   assign word_last     = hold_vld & ({1'b0, idx} == (hold_n - 3'd1));
   assign out_acc       = hold_vld & out_prdy;
   assign end_acc       = out_acc & (atom_cnt == cfg);
   assign in_prdy       = (state == RUN) & (~hold_vld | (out_acc & word_last));
   assign in_acc        = in_pvld & in_prdy;
   assign out_pvld      = hold_vld;
   assign out_word_last = word_last;
   assign out_layer_end = hold_vld & (atom_cnt == cfg);

   always_comb begin
      out_data = hold_data[0 +: AM_DW];
      case (idx)
         2'd1:    out_data = hold_data[AM_DW +: AM_DW];
         2'd2:    out_data = hold_data[2*AM_DW +: AM_DW];
         2'd3:    out_data = hold_data[3*AM_DW +: AM_DW];
         default: out_data = hold_data[0 +: AM_DW];
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (op_en) state_nxt = RUN;
         RUN:     if (end_acc) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) state <= IDLE;
      else                  state <= state_nxt;
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         cfg        <= '0;
         atom_cnt   <= '0;
         hold_vld   <= 1'b0;
         hold_data  <= '0;
         hold_n     <= 3'd0;
         idx        <= 2'd0;
         layer_done <= 1'b0;
         err_mask   <= 1'b0;
         err_ovf    <= 1'b0;
      end else begin
         layer_done <= end_acc;
         if (state == IDLE) begin
            if (op_en) begin
               cfg      <= cfg_atom_num_m1;
               atom_cnt <= '0;
               err_mask <= 1'b0;
               err_ovf  <= 1'b0;
            end
         end else begin
            if (out_acc) begin
               atom_cnt <= atom_cnt + 1'b1;
               if (!word_last) idx <= idx + 1'b1;
               else            hold_vld <= 1'b0;
            end
            if (in_acc) begin
               if (in_mask != 4'd0) begin
                  hold_vld  <= 1'b1;
                  hold_data <= in_data[4*AM_DW-1:0];
                  hold_n    <= in_n;
                  idx       <= 2'd0;
               end else begin
                  err_mask <= 1'b1;
               end
            end
            // Anything still held or arriving with the end atom is dropped.
            if (end_acc) begin
               hold_vld <= 1'b0;
               idx      <= 2'd0;
               if (!word_last || (in_acc && (in_mask != 4'd0))) err_ovf <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sdp_rdma_atom_split.sv
// Directed bench for sdp_rdma_atom_split: streams packed words and checks the atom stream,
// layer end marking, done pulse, error flags and reset behaviour against hand-computed values.
module tb_sdp_rdma_atom_split;
   localparam int AM_DW = 256;
   localparam int CNT_W = 14;
   localparam int WW    = 4*AM_DW+4;

   logic              clk;
   logic              rstn;
   logic              op_en;
   logic [CNT_W-1:0]  cfg;
   logic              in_pvld;
   logic              in_prdy;
   logic [WW-1:0]     in_data;
   logic              out_pvld;
   logic              out_prdy;
   logic [AM_DW-1:0]  out_data;
   logic              out_word_last;
   logic              out_layer_end;
   logic              layer_done;
   logic              err_mask;
   logic              err_ovf;

   int n_cmp;
   int n_fail;

   logic [WW-1:0]     word_q[$];
   logic [AM_DW-1:0]  exp_q[$];
   logic [AM_DW-1:0]  obs_data[$];
   bit                obs_last[$];
   bit                obs_end[$];
   int                obs_cyc[$];
   bit                pv_log[64];
   bit                prdy_log[64];
   logic [7:0]        tag_log[64];
   int                done_cyc;

   sdp_rdma_atom_split #(.AM_DW(AM_DW), .CNT_W(CNT_W)) dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .op_en           (op_en),
      .cfg_atom_num_m1 (cfg),
      .in_pvld         (in_pvld),
      .in_prdy         (in_prdy),
      .in_data         (in_data),
      .out_pvld        (out_pvld),
      .out_prdy        (out_prdy),
      .out_data        (out_data),
      .out_word_last   (out_word_last),
      .out_layer_end   (out_layer_end),
      .layer_done      (layer_done),
      .err_mask        (err_mask),
      .err_ovf         (err_ovf)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [AM_DW-1:0] mk_atom(input logic [7:0] tag);
      return {(AM_DW/8){tag}};
   endfunction

   function automatic logic [WW-1:0] mk_word(input logic [7:0] base, input logic [3:0] mask);
      logic [WW-1:0] w;
      logic [7:0]    t;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         t = base + 8'(k);
         w[k*AM_DW +: AM_DW] = mk_atom(t);
      end
      w[4*AM_DW +: 4] = mask;
      return w;
   endfunction

   // driver tasks
   task automatic start_layer(input logic [CNT_W-1:0] n_m1);
      @(negedge clk);
      op_en = 1'b1;
      cfg   = n_m1;
      @(negedge clk);
      op_en = 1'b0;
   endtask

   // Presents word_q, records accepted atoms and per-cycle status; stops on layer_done or after max_cyc.
   // mode 0: out_prdy held high; mode 1: out_prdy high on even cycles only.
   task automatic run(input int mode, input int max_cyc);
      obs_data.delete();
      obs_last.delete();
      obs_end.delete();
      obs_cyc.delete();
      done_cyc = -1;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         in_pvld  = (word_q.size() > 0);
         in_data  = in_pvld ? word_q[0] : '0;
         out_prdy = (mode == 0) ? 1'b1 : ((c % 2) == 0);
         #1;
         pv_log[c]   = out_pvld;
         prdy_log[c] = in_prdy;
         tag_log[c]  = out_data[7:0];
         if (out_pvld && out_prdy) begin
            obs_data.push_back(out_data);
            obs_last.push_back(out_word_last);
            obs_end.push_back(out_layer_end);
            obs_cyc.push_back(c);
         end
         if (layer_done) begin
            done_cyc = c;
            break;
         end
         if (in_pvld && in_prdy) void'(word_q.pop_front());
      end
      @(posedge clk);
      #1;
      in_pvld  = 1'b0;
      out_prdy = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; op_en = 1'b0; cfg = '0; in_pvld = 1'b1; in_data = mk_word(8'h01, 4'hf); out_prdy = 1'b1;
      #12;
      n_cmp++;
      if ({in_prdy, out_pvld, out_word_last, out_layer_end, layer_done, err_mask, err_ovf} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 0000000",
                  {in_prdy, out_pvld, out_word_last, out_layer_end, layer_done, err_mask, err_ovf});
      end
      n_cmp++;
      if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
      @(negedge clk); rstn = 1'b1;
      @(negedge clk); #1;
      n_cmp++;
      if (in_prdy !== 1'b0 || out_pvld !== 1'b0) begin
         n_fail++; $display("FAIL idle_no_xfer: in_prdy=%b out_pvld=%b want 0 0", in_prdy, out_pvld);
      end
      in_pvld = 1'b0; out_prdy = 1'b0;
   endtask

   task automatic test_two_full();
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(mk_atom(8'hA0 + 8'(i)));
      for (int i = 0; i < 4; i++) exp_q.push_back(mk_atom(8'hB0 + 8'(i)));
      start_layer(14'd7);
      word_q.push_back(mk_word(8'hA0, 4'hf));
      word_q.push_back(mk_word(8'hB0, 4'hf));
      run(0, 30);
      n_cmp++;
      if (obs_data.size() != 8) begin n_fail++; $display("FAIL full_count: got %0d want 8", obs_data.size()); end
      for (int i = 0; i < 8 && i < obs_data.size(); i++) begin
         n_cmp++;
         if (obs_data[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_data[%0d]: got %h want %h", i, obs_data[i][7:0], exp_q[i][7:0]); end
         n_cmp++;
         if (obs_cyc[i] != i + 1) begin n_fail++; $display("FAIL full_cyc[%0d]: got %0d want %0d", i, obs_cyc[i], i + 1); end
         n_cmp++;
         if (obs_last[i] !== (i == 3 || i == 7)) begin n_fail++; $display("FAIL full_last[%0d]: got %b want %b", i, obs_last[i], (i == 3 || i == 7)); end
         n_cmp++;
         if (obs_end[i] !== (i == 7)) begin n_fail++; $display("FAIL full_end[%0d]: got %b want %b", i, obs_end[i], (i == 7)); end
      end
      n_cmp++;
      if (prdy_log[4] !== 1'b1) begin n_fail++; $display("FAIL full_prdy_boundary: got %b want 1", prdy_log[4]); end
      n_cmp++;
      if (done_cyc != 9) begin n_fail++; $display("FAIL full_done_cyc: got %0d want 9", done_cyc); end
      n_cmp++;
      if ({in_prdy, err_mask, err_ovf} !== 3'b000) begin n_fail++; $display("FAIL full_after: got %b want 000", {in_prdy, err_mask, err_ovf}); end
   endtask

   task automatic test_partial_mask();
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(mk_atom(8'h10 + 8'(i)));
      exp_q.push_back(mk_atom(8'h20));
      exp_q.push_back(mk_atom(8'h21));
      start_layer(14'd5);
      word_q.push_back(mk_word(8'h10, 4'hf));
      word_q.push_back(mk_word(8'h20, 4'h3));
      run(0, 30);
      n_cmp++;
      if (obs_data.size() != 6) begin n_fail++; $display("FAIL part_count: got %0d want 6", obs_data.size()); end
      for (int i = 0; i < 6 && i < obs_data.size(); i++) begin
         n_cmp++;
         if (obs_data[i] !== exp_q[i]) begin n_fail++; $display("FAIL part_data[%0d]: got %h want %h", i, obs_data[i][7:0], exp_q[i][7:0]); end
         n_cmp++;
         if (obs_last[i] !== (i == 3 || i == 5)) begin n_fail++; $display("FAIL part_last[%0d]: got %b want %b", i, obs_last[i], (i == 3 || i == 5)); end
         n_cmp++;
         if (obs_end[i] !== (i == 5)) begin n_fail++; $display("FAIL part_end[%0d]: got %b want %b", i, obs_end[i], (i == 5)); end
      end
      n_cmp++;
      if (done_cyc != 7) begin n_fail++; $display("FAIL part_done_cyc: got %0d want 7", done_cyc); end
      n_cmp++;
      if ({err_mask, err_ovf} !== 2'b00) begin n_fail++; $display("FAIL part_err: got %b want 00", {err_mask, err_ovf}); end
   endtask

   task automatic test_backpressure();
      start_layer(14'd2);
      word_q.push_back(mk_word(8'h30, 4'h7));
      run(1, 30);
      n_cmp++;
      if (obs_data.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", obs_data.size()); end
      for (int i = 0; i < 3 && i < obs_data.size(); i++) begin
         n_cmp++;
         if (obs_cyc[i] != 2*i + 2) begin n_fail++; $display("FAIL bp_cyc[%0d]: got %0d want %0d", i, obs_cyc[i], 2*i + 2); end
         n_cmp++;
         if (obs_data[i] !== mk_atom(8'h30 + 8'(i))) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, obs_data[i][7:0], 8'h30 + 8'(i)); end
      end
      for (int c = 1; c <= 5; c += 2) begin
         n_cmp++;
         if (pv_log[c] !== 1'b1 || tag_log[c] !== 8'h30 + 8'((c - 1) / 2)) begin
            n_fail++; $display("FAIL bp_stall[%0d]: pvld=%b tag=%h want 1 %h", c, pv_log[c], tag_log[c], 8'h30 + 8'((c - 1) / 2));
         end
      end
      for (int c = 1; c <= 6; c++) begin
         n_cmp++;
         if (prdy_log[c] !== (c == 6)) begin n_fail++; $display("FAIL bp_in_prdy[%0d]: got %b want %b", c, prdy_log[c], (c == 6)); end
      end
      n_cmp++;
      if (done_cyc != 7) begin n_fail++; $display("FAIL bp_done_cyc: got %0d want 7", done_cyc); end
   endtask

   task automatic test_mask_zero();
      int exp_cyc[8];
      exp_cyc = '{1, 2, 3, 4, 6, 7, 8, 9};
      start_layer(14'd7);
      word_q.push_back(mk_word(8'h40, 4'hf));
      word_q.push_back(mk_word(8'hE0, 4'h0));
      word_q.push_back(mk_word(8'h60, 4'hf));
      run(0, 30);
      n_cmp++;
      if (obs_data.size() != 8) begin n_fail++; $display("FAIL m0_count: got %0d want 8", obs_data.size()); end
      for (int i = 0; i < 8 && i < obs_data.size(); i++) begin
         n_cmp++;
         if (obs_cyc[i] != exp_cyc[i]) begin n_fail++; $display("FAIL m0_cyc[%0d]: got %0d want %0d", i, obs_cyc[i], exp_cyc[i]); end
         n_cmp++;
         if (obs_data[i][7:0] !== ((i < 4) ? 8'h40 + 8'(i) : 8'h60 + 8'(i - 4))) begin
            n_fail++; $display("FAIL m0_data[%0d]: got %h", i, obs_data[i][7:0]);
         end
      end
      n_cmp++;
      if (pv_log[5] !== 1'b0) begin n_fail++; $display("FAIL m0_gap: got %b want 0", pv_log[5]); end
      n_cmp++;
      if (done_cyc != 10) begin n_fail++; $display("FAIL m0_done_cyc: got %0d want 10", done_cyc); end
      n_cmp++;
      if ({err_mask, err_ovf} !== 2'b10) begin n_fail++; $display("FAIL m0_err: got %b want 10", {err_mask, err_ovf}); end
   endtask

   task automatic test_overflow();
      start_layer(14'd2);
      n_cmp++;
      if (err_mask !== 1'b0) begin n_fail++; $display("FAIL ovf_err_clear: got %b want 0", err_mask); end
      word_q.push_back(mk_word(8'h70, 4'hf));
      run(0, 30);
      n_cmp++;
      if (obs_data.size() != 3) begin n_fail++; $display("FAIL ovf_count: got %0d want 3", obs_data.size()); end
      n_cmp++;
      if (obs_end.size() == 3 && (obs_end[2] !== 1'b1 || obs_last[2] !== 1'b0)) begin
         n_fail++; $display("FAIL ovf_end_atom: end=%b last=%b want 1 0", obs_end[2], obs_last[2]);
      end
      n_cmp++;
      if (done_cyc != 4) begin n_fail++; $display("FAIL ovf_done_cyc: got %0d want 4", done_cyc); end
      @(negedge clk);
      in_pvld = 1'b1; in_data = mk_word(8'h80, 4'hf); out_prdy = 1'b1;
      #1;
      n_cmp++;
      if ({in_prdy, out_pvld, err_mask, err_ovf} !== 4'b0001) begin
         n_fail++; $display("FAIL ovf_idle: got %b want 0001", {in_prdy, out_pvld, err_mask, err_ovf});
      end
      in_pvld = 1'b0; out_prdy = 1'b0;
   endtask

   task automatic test_reset_mid();
      start_layer(14'd7);
      word_q.push_back(mk_word(8'h90, 4'hf));
      run(0, 3);
      n_cmp++;
      if (obs_data.size() != 2) begin n_fail++; $display("FAIL rst_pre_count: got %0d want 2", obs_data.size()); end
      rstn = 1'b0;
      #1;
      n_cmp++;
      if ({in_prdy, out_pvld, out_word_last, out_layer_end, layer_done, err_mask, err_ovf} !== 7'b0 || out_data !== '0) begin
         n_fail++; $display("FAIL rst_mid_outputs: flags=%b data=%h want 0",
                             {in_prdy, out_pvld, out_word_last, out_layer_end, layer_done, err_mask, err_ovf}, out_data[7:0]);
      end
      @(negedge clk); rstn = 1'b1;
      word_q.delete();
      start_layer(14'd3);
      word_q.push_back(mk_word(8'hC0, 4'hf));
      run(0, 30);
      n_cmp++;
      if (obs_data.size() != 4) begin n_fail++; $display("FAIL rst_restart_count: got %0d want 4", obs_data.size()); end
      n_cmp++;
      if (obs_end.size() == 4 && (obs_end[3] !== 1'b1 || obs_end[2] !== 1'b0 || obs_data[0] !== mk_atom(8'hC0))) begin
         n_fail++; $display("FAIL rst_restart_end: end3=%b end2=%b d0=%h", obs_end[3], obs_end[2], obs_data[0][7:0]);
      end
      n_cmp++;
      if (done_cyc != 5) begin n_fail++; $display("FAIL rst_restart_done: got %0d want 5", done_cyc); end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      test_reset();
      test_two_full();
      test_partial_mask();
      test_backpressure();
      test_mask_zero();
      test_overflow();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
